// File: rtl/sync_frame_deframer.sv
// sync_frame_deframer
//
// Locks onto a framed serial stream (SYNC_LEN-bit sync word followed by
// PAYLOAD_BITS payload bits) using the upstream sync detector's flag, and
// emits each payload as a parallel word.  A flywheel tolerates up to
// MAX_MISSES-1 consecutive corrupted syncs; the next miss drops lock and
// returns to HUNT.
//
// Ports:
//   clk           single clock, all logic on posedge
//   rst_n         asynchronous active-low reset
//   new_bit       serial stream, one bit per cycle
//   sync_detected detector flag, high the cycle after the last sync bit
//   word          assembled payload, MSB = first payload bit received
//   word_valid    one-cycle pulse, word is valid
//   word_err      qualifies word_valid: frame was flywheeled (sync missed)
//   locked        alignment confirmed by a hit at an expected boundary
//   sync_lost     one-cycle pulse when lock is dropped
module sync_frame_deframer #(
  parameter int PAYLOAD_BITS = 8,
  parameter int SYNC_LEN     = 6,
  parameter int MAX_MISSES   = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    new_bit,
  input  logic                    sync_detected,
  output logic [PAYLOAD_BITS-1:0] word,
  output logic                    word_valid,
  output logic                    word_err,
  output logic                    locked,
  output logic                    sync_lost
);

  localparam int CNT_MAX = (PAYLOAD_BITS > SYNC_LEN) ? PAYLOAD_BITS : SYNC_LEN;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int MW      = $clog2(MAX_MISSES + 1);

  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] PAYLOAD = 2'd1;
  localparam logic [1:0] GAP     = 2'd2;

  localparam logic [CW-1:0] LAST_BIT   = CW'(PAYLOAD_BITS - 1);
  localparam logic [CW-1:0] BOUNDARY   = CW'(SYNC_LEN);
  // A miss at this count is the one that exhausts the flywheel.
  localparam logic [MW-1:0] MISS_LIMIT = MW'(MAX_MISSES - 1);

  logic [1:0]              state, state_next;
  logic [CW-1:0]           cnt, cnt_next;
  logic [MW-1:0]           misses, misses_next;
  logic [PAYLOAD_BITS-1:0] shift, shift_next;
  logic                    err, err_next;
  logic                    locked_next;
  logic [PAYLOAD_BITS-1:0] word_next;
  logic                    word_valid_next;
  logic                    word_err_next;
  logic                    sync_lost_next;
  logic                    start;
  logic                    start_err;

  logic [PAYLOAD_BITS-1:0] first_bit;
  logic [PAYLOAD_BITS-1:0] shifted;

  // A shift works for any width, including the single-bit payload case.
  assign first_bit = PAYLOAD_BITS'(new_bit);
  assign shifted   = (shift << 1) | first_bit;

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    misses_next     = misses;
    shift_next      = shift;
    err_next        = err;
    locked_next     = locked;
    word_next       = word;
    word_valid_next = 1'b0;
    word_err_next   = 1'b0;
    sync_lost_next  = 1'b0;
    start           = 1'b0;
    start_err       = 1'b0;

    case (state)
      HUNT: begin
        if (sync_detected) start = 1'b1;
      end

      PAYLOAD: begin
        shift_next = shifted;
        if (cnt == LAST_BIT) begin
          word_next       = shifted;
          word_valid_next = 1'b1;
          word_err_next   = err;
          state_next      = GAP;
          cnt_next        = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end

      GAP: begin
        if (cnt != BOUNDARY) begin
          // Skipping the sync bits of the next frame.
          cnt_next = cnt + CW'(1);
        end else if (sync_detected) begin
          misses_next = '0;
          locked_next = 1'b1;
          start       = 1'b1;
        end else if (misses == MISS_LIMIT) begin
          // Boundary bit is discarded; re-acquire from scratch.
          state_next     = HUNT;
          cnt_next       = '0;
          misses_next    = '0;
          locked_next    = 1'b0;
          sync_lost_next = 1'b1;
        end else begin
          // Flywheel: trust the expected alignment, mark the frame.
          misses_next = misses + MW'(1);
          start       = 1'b1;
          start_err   = 1'b1;
        end
      end

      default: begin
        state_next = HUNT;
        cnt_next   = '0;
      end
    endcase

    // Frame start: this cycle's bit is the first payload bit.  With a
    // one-bit payload it is also the last, so the word is emitted directly.
    if (start) begin
      shift_next = first_bit;
      err_next   = start_err;
      if (PAYLOAD_BITS == 1) begin
        word_next       = first_bit;
        word_valid_next = 1'b1;
        word_err_next   = start_err;
        state_next      = GAP;
        cnt_next        = '0;
      end else begin
        state_next = PAYLOAD;
        cnt_next   = CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      cnt        <= '0;
      misses     <= '0;
      shift      <= '0;
      err        <= 1'b0;
      locked     <= 1'b0;
      word       <= '0;
      word_valid <= 1'b0;
      word_err   <= 1'b0;
      sync_lost  <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      misses     <= misses_next;
      shift      <= shift_next;
      err        <= err_next;
      locked     <= locked_next;
      word       <= word_next;
      word_valid <= word_valid_next;
      word_err   <= word_err_next;
      sync_lost  <= sync_lost_next;
    end
  end

endmodule
